ball_motion: RTL and testbench

//  Owns the ball: holds position and velocity, advances once per frame, reflects off

---
 rtl/ball_motion_pkg.sv | 32 +++
 rtl/ball_axis_step.sv | 69 ++++++
 rtl/ball_motion.sv | 163 ++++++++++++++++
 tb/tb_ball_motion.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ball_motion_pkg.sv
// ----------------------------------------------------------------------------
// ball_motion_pkg
// Shared definitions for the ball logic:
//   dir_e        - bounce direction codes, shared with bounce_detect
//                  (UP=0, RIGHT=1, DOWN=2, LEFT=3)
//   ball_state_e - ball controller state encodings
//   SIGN_POS/NEG - velocity sign encoding used for dx/dy
//   COORD_W      - width of every screen coordinate
// ----------------------------------------------------------------------------
package ball_motion_pkg;

   localparam int COORD_W = 10;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_RIGHT = 2'd1,
      DIR_DOWN  = 2'd2,
      DIR_LEFT  = 2'd3
   } dir_e;

   typedef enum logic [1:0] {
      ST_HOLD   = 2'd0,
      ST_RUN    = 2'd1,
      ST_STEP   = 2'd2,
      ST_SAMPLE = 2'd3
   } ball_state_e;

   // A velocity sign of 1 means the coordinate increases each frame.
   localparam logic SIGN_POS = 1'b1;
   localparam logic SIGN_NEG = 1'b0;

endpackage

// File: rtl/ball_axis_step.sv
// ----------------------------------------------------------------------------
// ball_axis_step
// Computes one frame of motion along a single axis, including wall reflection.
// Ports:
//   pos      in  current centre coordinate
//   dir      in  current velocity sign (1 = increasing)
//   lo, hi   in  low and high wall coordinates
//   speed    in  pixels moved per frame
//   radius   in  ball radius
//   next_pos out coordinate after this frame
//   next_dir out velocity sign after this frame
//   hit_lo   out ball reached the low wall this frame
//   hit_hi   out ball reached the high wall this frame
// HI_INCLUSIVE selects whether touching the high wall exactly counts as a hit
// (the floor uses >=, the side walls use >).
// ----------------------------------------------------------------------------
module ball_axis_step
   import ball_motion_pkg::*;
#(
   parameter bit HI_INCLUSIVE = 1'b0
) (
   input  logic [COORD_W-1:0] pos,
   input  logic               dir,
   input  logic [COORD_W-1:0] lo,
   input  logic [COORD_W-1:0] hi,
   input  logic [3:0]         speed,
   input  logic [5:0]         radius,
   output logic [COORD_W-1:0] next_pos,
   output logic               next_dir,
   output logic               hit_lo,
   output logic               hit_hi
);

   // Comparisons are done one bit wider than the coordinate so that neither
   // the limit nor the projected edge can wrap before being compared.
   logic [COORD_W:0] lo_limit;
   logic [COORD_W:0] hi_reach;
   logic             hi_over;

   assign lo_limit = {1'b0, lo}  + (COORD_W+1)'(radius) + (COORD_W+1)'(speed);
   assign hi_reach = {1'b0, pos} + (COORD_W+1)'(radius) + (COORD_W+1)'(speed);
   assign hi_over  = HI_INCLUSIVE ? (hi_reach >= {1'b0, hi}) : (hi_reach > {1'b0, hi});

   always_comb begin
      next_pos = pos;
      next_dir = dir;
      hit_lo   = 1'b0;
      hit_hi   = 1'b0;
      if (dir == SIGN_NEG) begin
         // Moving toward the low wall: clamp the edge onto the wall and turn round.
         if ({1'b0, pos} < lo_limit) begin
            next_pos = lo + COORD_W'(radius);
            next_dir = SIGN_POS;
            hit_lo   = 1'b1;
         end else begin
            next_pos = pos - COORD_W'(speed);
         end
      end else begin
         if (hi_over) begin
            next_pos = hi - COORD_W'(radius);
            next_dir = SIGN_NEG;
            hit_hi   = 1'b1;
         end else begin
            next_pos = pos + COORD_W'(speed);
         end
      end
   end

endmodule

// File: rtl/ball_motion.sv
// ----------------------------------------------------------------------------
// ball_motion
// Owns the ball: holds its position and velocity, advances it once per video
// frame, reflects it off the playfield walls and applies the verdict of the
// external bounce_detect block one cycle after each move.
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   frame_tick          one-cycle pulse per video frame
//   launch              one-cycle pulse releasing the ball from the paddle
//   paddle_x/paddle_top paddle centre x and top edge y
//   bounced/direction   bounce_detect verdict for the current b_x/b_y
//   b_x, b_y, b_radius  ball centre and radius
//   moving              ball is in flight (not held on the paddle)
//   hit                 one-cycle pulse: target bounce accepted
//   lost                one-cycle pulse: ball reached the floor
// ----------------------------------------------------------------------------
module ball_motion
   import ball_motion_pkg::*;
#(
   parameter int unsigned RADIUS  = 4,
   parameter int unsigned SPEED   = 2,
   parameter int unsigned FIELD_L = 8,
   parameter int unsigned FIELD_R = 631,
   parameter int unsigned FIELD_T = 8,
   parameter int unsigned FIELD_B = 479,
   parameter int unsigned X_RST   = 320,
   parameter int unsigned Y_RST   = 440
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_tick,
   input  logic               launch,
   input  logic [COORD_W-1:0] paddle_x,
   input  logic [COORD_W-1:0] paddle_top,
   input  logic               bounced,
   input  logic [1:0]         direction,
   output logic [COORD_W-1:0] b_x,
   output logic [COORD_W-1:0] b_y,
   output logic [5:0]         b_radius,
   output logic               moving,
   output logic               hit,
   output logic               lost
);

   // While held, the ball rests just above the paddle's top edge.
   localparam logic [COORD_W-1:0] HOLD_OFFSET = COORD_W'(RADIUS + 1);

   ball_state_e        state;
   logic               dx;
   logic               dy;

   logic [COORD_W-1:0] x_next;
   logic [COORD_W-1:0] y_next;
   logic               x_next_dir;
   logic               y_next_dir;
   logic               x_hit_lo;
   logic               x_hit_hi;
   logic               y_hit_lo;
   logic               y_hit_hi;
   logic               unused_wall_hits;

   assign b_radius = 6'(RADIUS);

   // Side and ceiling hits are fully handled inside the axis steppers.
   assign unused_wall_hits = ^{x_hit_lo, x_hit_hi, y_hit_lo};

   ball_axis_step #(
      .HI_INCLUSIVE(1'b0)
   ) u_step_x (
      .pos      (b_x),
      .dir      (dx),
      .lo       (COORD_W'(FIELD_L)),
      .hi       (COORD_W'(FIELD_R)),
      .speed    (4'(SPEED)),
      .radius   (6'(RADIUS)),
      .next_pos (x_next),
      .next_dir (x_next_dir),
      .hit_lo   (x_hit_lo),
      .hit_hi   (x_hit_hi)
   );

   // The floor is not a wall: reaching it means the ball is lost.
   ball_axis_step #(
      .HI_INCLUSIVE(1'b1)
   ) u_step_y (
      .pos      (b_y),
      .dir      (dy),
      .lo       (COORD_W'(FIELD_T)),
      .hi       (COORD_W'(FIELD_B)),
      .speed    (4'(SPEED)),
      .radius   (6'(RADIUS)),
      .next_pos (y_next),
      .next_dir (y_next_dir),
      .hit_lo   (y_hit_lo),
      .hit_hi   (y_hit_hi)
   );

   // Ball controller. Walls act in STEP, the target verdict in SAMPLE, so a
   // frame that does both applies the wall first. Target bounces force the
   // velocity sign rather than toggling it, so a target that stays overlapped
   // across several frames cannot keep re-reflecting the ball. frame_tick is
   // only honoured in RUN; ticks arriving in STEP/SAMPLE are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_HOLD;
         b_x    <= COORD_W'(X_RST);
         b_y    <= COORD_W'(Y_RST);
         dx     <= SIGN_POS;
         dy     <= SIGN_NEG;
         moving <= 1'b0;
         hit    <= 1'b0;
         lost   <= 1'b0;
      end else begin
         hit  <= 1'b0;
         lost <= 1'b0;
         case (state)
            ST_HOLD: begin
               b_x <= paddle_x;
               b_y <= paddle_top - HOLD_OFFSET;
               if (launch) begin
                  state  <= ST_RUN;
                  dx     <= SIGN_POS;
                  dy     <= SIGN_NEG;
                  moving <= 1'b1;
               end
            end
            ST_RUN: begin
               if (frame_tick) begin
                  state <= ST_STEP;
               end
            end
            ST_STEP: begin
               if (y_hit_hi) begin
                  lost   <= 1'b1;
                  moving <= 1'b0;
                  state  <= ST_HOLD;
               end else begin
                  b_x   <= x_next;
                  b_y   <= y_next;
                  dx    <= x_next_dir;
                  dy    <= y_next_dir;
                  state <= ST_SAMPLE;
               end
            end
            ST_SAMPLE: begin
               if (bounced) begin
                  hit <= 1'b1;
                  case (dir_e'(direction))
                     DIR_UP:    dy <= SIGN_NEG;
                     DIR_DOWN:  dy <= SIGN_POS;
                     DIR_LEFT:  dx <= SIGN_NEG;
                     DIR_RIGHT: dx <= SIGN_POS;
                     default:   dx <= dx;
                  endcase
               end
               state <= ST_RUN;
            end
            default: state <= ST_HOLD;
         endcase
      end
   end

endmodule

// File: tb/tb_ball_motion.sv
// ----------------------------------------------------------------------------
// tb_ball_motion
// Directed testbench for ball_motion with hand-computed expected positions.
// Inputs change and outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_ball_motion;

   logic       clk;
   logic       rst_n;
   logic       frame_tick;
   logic       launch;
   logic [9:0] paddle_x;
   logic [9:0] paddle_top;
   logic       bounced;
   logic [1:0] direction;
   logic [9:0] b_x;
   logic [9:0] b_y;
   logic [5:0] b_radius;
   logic       moving;
   logic       hit;
   logic       lost;

   int checkCount;
   int failCount;

   localparam logic [1:0] D_UP   = 2'd0;
   localparam logic [1:0] D_DOWN = 2'd2;

   ball_motion dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_tick (frame_tick),
      .launch     (launch),
      .paddle_x   (paddle_x),
      .paddle_top (paddle_top),
      .bounced    (bounced),
      .direction  (direction),
      .b_x        (b_x),
      .b_y        (b_y),
      .b_radius   (b_radius),
      .moving     (moving),
      .hit        (hit),
      .lost       (lost)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Drives launch/frame_tick for exactly one rising edge.
   task automatic applyStimulus(input logic doLaunch, input logic doTick);
      launch     = doLaunch;
      frame_tick = doTick;
      @(negedge clk);
      launch     = 1'b0;
      frame_tick = 1'b0;
   endtask

   // One full frame: tick, move (checked), sample (hit checked).
   task automatic stepFrame(input string tag, input logic [9:0] expX,
                            input logic [9:0] expY, input logic expHit);
      applyStimulus(1'b0, 1'b1);
      @(negedge clk);
      checkOutput({tag, ".x"}, 16'(b_x), 16'(expX));
      checkOutput({tag, ".y"}, 16'(b_y), 16'(expY));
      checkOutput({tag, ".hit_early"}, 16'(hit), 16'd0);
      @(negedge clk);
      checkOutput({tag, ".hit"}, 16'(hit), 16'(expHit));
   endtask

   // Pulses reset with new paddle inputs; returns once HOLD has loaded them.
   task automatic resetDut(input logic [9:0] px, input logic [9:0] pt);
      rst_n      = 1'b0;
      paddle_x   = px;
      paddle_top = pt;
      bounced    = 1'b0;
      direction  = D_UP;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      checkCount = 0;
      failCount  = 0;
      rst_n      = 1'b0;
      frame_tick = 1'b0;
      launch     = 1'b0;
      paddle_x   = 10'd200;
      paddle_top = 10'd460;
      bounced    = 1'b0;
      direction  = D_UP;

      // Reset values
      @(negedge clk);
      checkOutput("rst.x", 16'(b_x), 16'd320);
      checkOutput("rst.y", 16'(b_y), 16'd440);
      checkOutput("rst.moving", 16'(moving), 16'd0);
      checkOutput("rst.hit", 16'(hit), 16'd0);
      checkOutput("rst.lost", 16'(lost), 16'd0);
      checkOutput("rst.radius", 16'(b_radius), 16'd4);

      // HOLD follows the paddle
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("hold.x", 16'(b_x), 16'd200);
      checkOutput("hold.y", 16'(b_y), 16'd455);
      checkOutput("hold.moving", 16'(moving), 16'd0);

      // Launch and three free frames: +2 in x, -2 in y each
      applyStimulus(1'b1, 1'b0);
      checkOutput("launch.moving", 16'(moving), 16'd1);
      stepFrame("free1", 10'd202, 10'd453, 1'b0);
      stepFrame("free2", 10'd204, 10'd451, 1'b0);
      stepFrame("free3", 10'd206, 10'd449, 1'b0);
      checkOutput("free.moving", 16'(moving), 16'd1);

      // Target DOWN turns dy positive; hit is a single pulse
      bounced   = 1'b1;
      direction = D_DOWN;
      stepFrame("tgtDown", 10'd208, 10'd447, 1'b1);
      direction = D_UP;
      @(negedge clk);
      checkOutput("tgtDown.hitDrop", 16'(hit), 16'd0);

      // Target UP held for two frames: dy forced negative, not re-toggled
      stepFrame("tgtUp1", 10'd210, 10'd449, 1'b1);
      stepFrame("tgtUp2", 10'd212, 10'd447, 1'b1);
      bounced = 1'b0;
      stepFrame("tgtUp3", 10'd214, 10'd445, 1'b0);

      // Ticks arriving during STEP and SAMPLE are dropped
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1);
      @(negedge clk);
      @(negedge clk);
      checkOutput("dropTick.x", 16'(b_x), 16'd216);
      checkOutput("dropTick.y", 16'(b_y), 16'd443);

      // Right wall: 626+4+2 > 631 clamps to 627 and reverses
      resetDut(10'd626, 10'd460);
      applyStimulus(1'b1, 1'b0);
      stepFrame("rwall1", 10'd627, 10'd453, 1'b0);
      stepFrame("rwall2", 10'd625, 10'd451, 1'b0);

      // Top wall: 12 < 8+4+2 clamps to 12 and reverses
      resetDut(10'd300, 10'd17);
      checkOutput("twall.hold.y", 16'(b_y), 16'd12);
      applyStimulus(1'b1, 1'b0);
      stepFrame("twall1", 10'd302, 10'd12, 1'b0);
      stepFrame("twall2", 10'd304, 10'd14, 1'b0);

      // Floor: 474+4+2 >= 479 loses the ball
      resetDut(10'd100, 10'd479);
      applyStimulus(1'b1, 1'b0);
      bounced   = 1'b1;
      direction = D_DOWN;
      stepFrame("floor1", 10'd102, 10'd472, 1'b1);
      bounced = 1'b0;
      stepFrame("floor2", 10'd104, 10'd474, 1'b0);
      applyStimulus(1'b0, 1'b1);
      @(negedge clk);
      checkOutput("floor.lost", 16'(lost), 16'd1);
      checkOutput("floor.moving", 16'(moving), 16'd0);
      paddle_x = 10'd150;
      @(negedge clk);
      checkOutput("floor.lostDrop", 16'(lost), 16'd0);
      checkOutput("floor.track.x", 16'(b_x), 16'd150);
      checkOutput("floor.track.y", 16'(b_y), 16'd474);

      // Launch and tick together: launch wins, tick is dropped
      applyStimulus(1'b1, 1'b1);
      checkOutput("launchTick.moving", 16'(moving), 16'd1);
      @(negedge clk);
      @(negedge clk);
      checkOutput("launchTick.x", 16'(b_x), 16'd150);
      checkOutput("launchTick.y", 16'(b_y), 16'd474);
      stepFrame("launchTick.f1", 10'd152, 10'd472, 1'b0);

      // Asynchronous reset while in SAMPLE with a pending bounce
      bounced   = 1'b1;
      direction = D_UP;
      applyStimulus(1'b0, 1'b1);
      @(negedge clk);
      checkOutput("midRst.preX", 16'(b_x), 16'd154);
      rst_n = 1'b0;
      #1;
      checkOutput("midRst.x", 16'(b_x), 16'd320);
      checkOutput("midRst.y", 16'(b_y), 16'd440);
      checkOutput("midRst.moving", 16'(moving), 16'd0);
      checkOutput("midRst.hit", 16'(hit), 16'd0);
      @(negedge clk);
      checkOutput("midRst.hitLater", 16'(hit), 16'd0);
      bounced = 1'b0;
      rst_n   = 1'b1;
      @(negedge clk);
      checkOutput("midRst.hold.x", 16'(b_x), 16'd150);
      checkOutput("midRst.hold.moving", 16'(moving), 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
